// File: rtl/two_of_five_pkg.sv
`default_nettype none
// ============================================================================
// Module   : two_of_five_pkg
// Purpose  : Shared types, constants and the 2-of-5 legality helper for the
//            two_of_five_rx serial receiver and anything that checks it.
// Revision : 1.0 - initial release
// ============================================================================
package two_of_five_pkg;

  // Width of one 2-out-of-5 code word
  localparam int W5 = 5;

  // Receiver framing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EVAL  = 2'd2
  } state_e;

  // True when exactly two of the five bits are set
  function automatic logic is_two_of_five(input logic [W5-1:0] word);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < W5; i++) begin
      ones = ones + {2'b00, word[i]};
    end
    return (ones == 3'd2);
  endfunction

endpackage : two_of_five_pkg
`default_nettype wire

// File: rtl/two_of_five_rx_popcount5.sv
`default_nettype none
// ============================================================================
// Module   : popcount5
// Purpose  : Combinational ones counter for one 5-bit code word.
// Revision : 1.0 - initial release
// ============================================================================
module popcount5
  import two_of_five_pkg::*;
(
  input  logic [W5-1:0] din,
  output logic [2:0]    cnt
);

  // Sum the five bits; result is 0..5 so three bits suffice
  always_comb begin
    cnt = 3'd0;
    for (int i = 0; i < W5; i++) begin
      cnt = cnt + {2'b00, din[i]};
    end
  end

endmodule : popcount5
`default_nettype wire

// File: rtl/two_of_five_rx.sv
`default_nettype none
// ============================================================================
// Module   : two_of_five_rx
// Purpose  : Serial receiver that frames 5-bit 2-out-of-5 words from a strobed
//            bit stream, validity-checks them and holds the result for the
//            seven-segment display decoder. Keeps a saturating error count.
// Revision : 1.0 - initial release
// ============================================================================
module two_of_five_rx
  import two_of_five_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int          ERRW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sync,
  input  logic            sstb,
  input  logic            sin,
  output logic            v,
  output logic            a,
  output logic            b,
  output logic            c,
  output logic            d,
  output logic            e,
  output logic            done,
  output logic            err,
  output logic            abort,
  output logic [ERRW-1:0] err_cnt
);

  // Idle count is compared one bit wider so TIMEOUT=65535 cannot wrap
  localparam logic [16:0]     TIMEOUT_L  = 17'(TIMEOUT);
  localparam logic [2:0]      LAST_BIT   = 3'(W5 - 1);
  localparam logic [ERRW-1:0] ERR_MAX    = {ERRW{1'b1}};
  localparam logic [ERRW-1:0] ERR_ONE    = {{(ERRW-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [W5-1:0]   sr_q, sr_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [15:0]     idle_q, idle_d;
  // Evaluated result waiting one cycle before it reaches the outputs
  logic            pend_q, pend_d;
  logic            pend_legal_q, pend_legal_d;
  logic [W5-1:0]   pend_word_q, pend_word_d;
  logic            v_q, v_d;
  logic [W5-1:0]   word_q, word_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;

  logic [2:0]      ones;
  logic            legal;
  logic [16:0]     idle_next;
  logic            timeout_hit;

  popcount5 u_popcount5 (
    .din (sr_q),
    .cnt (ones)
  );

  assign legal       = (ones == 3'd2);
  assign idle_next   = {1'b0, idle_q} + 17'd1;
  assign timeout_hit = (idle_next == TIMEOUT_L);

  // State register and all datapath flops, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bitcnt_q     <= 3'd0;
      idle_q       <= 16'd0;
      pend_q       <= 1'b0;
      pend_legal_q <= 1'b0;
      pend_word_q  <= '0;
      v_q          <= 1'b0;
      word_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_q      <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bitcnt_q     <= bitcnt_d;
      idle_q       <= idle_d;
      pend_q       <= pend_d;
      pend_legal_q <= pend_legal_d;
      pend_word_q  <= pend_word_d;
      v_q          <= v_d;
      word_q       <= word_d;
      done_q       <= done_d;
      err_q        <= err_d;
      abort_q      <= abort_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next-state logic: framing, re-sync, timeout and the single EVAL cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sync && sstb) state_d = SHIFT;
      end
      SHIFT: begin
        if (sstb && !sync && (bitcnt_q == LAST_BIT)) state_d = EVAL;
        else if (!sstb && timeout_hit)               state_d = IDLE;
      end
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered output updates
  always_comb begin
    sr_d         = sr_q;
    bitcnt_d     = bitcnt_q;
    idle_d       = idle_q;
    pend_d       = 1'b0;
    pend_legal_d = pend_legal_q;
    pend_word_d  = pend_word_q;
    v_d          = v_q;
    word_d       = word_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    abort_d      = 1'b0;
    err_cnt_d    = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (sync && sstb) begin
          sr_d     = {{(W5-1){1'b0}}, sin};
          bitcnt_d = 3'd1;
          idle_d   = 16'd0;
        end
      end
      SHIFT: begin
        if (sstb && sync) begin
          // Re-sync: drop the partial word, this bit starts a new frame
          abort_d  = 1'b1;
          sr_d     = {{(W5-1){1'b0}}, sin};
          bitcnt_d = 3'd1;
          idle_d   = 16'd0;
        end else if (sstb) begin
          sr_d[bitcnt_q] = sin;
          bitcnt_d       = bitcnt_q + 3'd1;
          idle_d         = 16'd0;
        end else if (timeout_hit) begin
          abort_d  = 1'b1;
          sr_d     = '0;
          bitcnt_d = 3'd0;
          idle_d   = 16'd0;
        end else begin
          idle_d = idle_next[15:0];
        end
      end
      EVAL: begin
        pend_d       = 1'b1;
        pend_legal_d = legal;
        pend_word_d  = legal ? sr_q : '0;
        sr_d         = '0;
        bitcnt_d     = 3'd0;
        idle_d       = 16'd0;
      end
      default: begin
        sr_d     = '0;
        bitcnt_d = 3'd0;
        idle_d   = 16'd0;
      end
    endcase

    // Result of the previous EVAL reaches the display bundle
    if (pend_q) begin
      v_d    = pend_legal_q;
      word_d = pend_word_q;
      done_d = 1'b1;
      err_d  = !pend_legal_q;
      if (!pend_legal_q && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_ONE;
      end
    end
  end

  assign v       = v_q;
  assign a       = word_q[0];
  assign b       = word_q[1];
  assign c       = word_q[2];
  assign d       = word_q[3];
  assign e       = word_q[4];
  assign done    = done_q;
  assign err     = err_q;
  assign abort   = abort_q;
  assign err_cnt = err_cnt_q;

endmodule : two_of_five_rx
`default_nettype wire

// File: tb/tb_two_of_five_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_two_of_five_rx
// Purpose  : Directed self-checking bench for two_of_five_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_two_of_five_rx;

  logic       clk = 1'b0;
  logic       rst, sync, sstb, sin;
  logic       v, a, b, c, d, e, done, err, abort;
  logic [7:0] err_cnt;
  logic [4:0] bundle;

  int n_checks  = 0;
  int n_fail    = 0;
  int done_seen = 0;

  assign bundle = {a, b, c, d, e};

  two_of_five_rx #(.TIMEOUT(255), .ERRW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .sync    (sync),
    .sstb    (sstb),
    .sin     (sin),
    .v       (v),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .e       (e),
    .done    (done),
    .err     (err),
    .abort   (abort),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Count done pulses shortly after each rising edge
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at a falling edge, return at the next falling edge
  task automatic cyc(input logic s, input logic st, input logic bit_in);
    sync = s;
    sstb = st;
    sin  = bit_in;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // w[4] is sent first and lands on a, w[0] lands on e
  task automatic send_word(input logic [4:0] w);
    cyc(1'b1, 1'b1, w[4]);
    cyc(1'b0, 1'b1, w[3]);
    cyc(1'b0, 1'b1, w[2]);
    cyc(1'b0, 1'b1, w[1]);
    cyc(1'b0, 1'b1, w[0]);
  endtask

  logic [4:0] ww [10];
  int         base;

  initial begin
    ww = '{5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010,
           5'b01100, 5'b10001, 5'b10010, 5'b10100, 5'b11000};
    rst = 1'b1; sync = 1'b0; sstb = 1'b0; sin = 1'b0;
    @(negedge clk);
    idle(2);
    chk("rst_v", v, 0);
    chk("rst_bundle", bundle, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_abort", abort, 0);
    chk("rst_errcnt", err_cnt, 0);
    rst = 1'b0;
    idle(1);

    // Legal word 0,1,0,1,0
    send_word(5'b01010);
    idle(1);
    chk("legal_early_done", done, 0);
    idle(1);
    chk("legal_v", v, 1);
    chk("legal_bundle", bundle, 5'b01010);
    chk("legal_done", done, 1);
    chk("legal_err", err, 0);
    chk("legal_errcnt", err_cnt, 0);
    idle(1);
    chk("legal_done_pulse", done, 0);
    chk("legal_v_hold", v, 1);

    // Illegal word 1,1,1,0,0
    send_word(5'b11100);
    idle(2);
    chk("illegal_v", v, 0);
    chk("illegal_bundle", bundle, 0);
    chk("illegal_done", done, 1);
    chk("illegal_err", err, 1);
    chk("illegal_errcnt", err_cnt, 1);
    idle(1);

    // Re-sync after three bits, then legal 1,0,0,0,1
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("resync_abort", abort, 1);
    chk("resync_no_done", done, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("resync_abort_pulse", abort, 0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    idle(2);
    chk("resync_v", v, 1);
    chk("resync_bundle", bundle, 5'b10001);
    chk("resync_done", done, 1);
    chk("resync_errcnt", err_cnt, 1);
    idle(1);

    // Timeout: two bits then 255 idle cycles
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    idle(254);
    chk("tmo_early_abort", abort, 0);
    idle(1);
    chk("tmo_abort", abort, 1);
    chk("tmo_v_hold", v, 1);
    chk("tmo_bundle_hold", bundle, 5'b10001);
    chk("tmo_no_done", done, 0);
    idle(1);
    chk("tmo_abort_pulse", abort, 0);
    cyc(1'b0, 1'b1, 1'b1);   // stray strobe in IDLE, ignored
    idle(1);

    // Gap of 254 cycles completes the frame: 0,1,1,0,0
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    idle(254);
    chk("gap254_no_abort", abort, 0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("gap254_v", v, 1);
    chk("gap254_bundle", bundle, 5'b01100);
    chk("gap254_done", done, 1);
    idle(1);

    // Reset after two bits
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    idle(1);
    chk("midrst_v", v, 0);
    chk("midrst_bundle", bundle, 0);
    chk("midrst_abort", abort, 0);
    chk("midrst_errcnt", err_cnt, 0);
    rst = 1'b0;
    idle(1);
    chk("midrst_abort_after", abort, 0);
    send_word(5'b00011);
    chk("midrst_no_resync_abort", abort, 0);
    idle(2);
    chk("midrst_v_after", v, 1);
    chk("midrst_bundle_after", bundle, 5'b00011);
    chk("midrst_done_after", done, 1);
    idle(1);

    // Back-to-back legal words, a sync+strobe lands in every EVAL cycle
    base = done_seen;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, ww[k][4]);
      if (k > 0) begin
        chk("b2b_bundle", bundle, ww[k-1]);
        chk("b2b_done", done, 1);
        chk("b2b_abort", abort, 0);
      end
      cyc(1'b0, 1'b1, ww[k][3]);
      cyc(1'b0, 1'b1, ww[k][2]);
      cyc(1'b0, 1'b1, ww[k][1]);
      cyc(1'b0, 1'b1, ww[k][0]);
      cyc(1'b1, 1'b1, 1'b1);
    end
    idle(1);
    chk("b2b_last_bundle", bundle, ww[9]);
    chk("b2b_last_v", v, 1);
    idle(2);
    chk("b2b_done_count", done_seen - base, 10);
    chk("b2b_errcnt", err_cnt, 0);

    // 300 illegal words: error count saturates at 255
    for (int k = 0; k < 300; k++) begin
      send_word(5'b11100);
      idle(1);
    end
    idle(1);
    chk("sat_errcnt", err_cnt, 255);
    chk("sat_err", err, 1);
    chk("sat_done", done, 1);
    chk("sat_v", v, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_two_of_five_rx
`default_nettype wire
